// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, interrupt/mret sequencer, wfi sleep and 64-bit counters
// for the 5-stage RV32 core. CSR ops and mret are executed in EXE.
module csr_trap_unit #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_en,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            mret,
    input  logic            wfi,
    input  logic            instret_inc,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic [1:0]      CSR_type,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] ID_pc,
    input  logic            ID_valid,
    input  logic [XLEN-1:0] IF_pc,
    output logic            CSR_interrupt,
    output logic            CSR_ret,
    output logic [XLEN-1:0] trap_pc,
    output logic            wfi_stall
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SLEEP = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic        mie_meie_reg;
    logic        mie_mtie_reg;
    logic [31:2] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:2] mepc_reg;
    logic [31:0] mcause_reg;
    logic        mip_meip_reg;
    logic        mip_mtip_reg;

    // cnt[0] = mcycle, cnt[1] = minstret
    logic [1:0][63:0] cnt;

    logic [31:0] mstatus_val;
    logic [31:0] mie_val;
    logic [31:0] mip_val;
    logic [31:0] mtvec_val;
    logic [31:0] mepc_val;
    logic [31:0] write_val;
    logic        csr_write;
    logic        pend_ext;
    logic        pend_tmr;
    logic        pending;
    logic        take;
    logic        irq_run;
    logic        irq_sleep;
    logic [31:0] mepc_entry;
    logic        unused_bits;

    // funct3[2] only selects zimm vs rs1, which is resolved upstream
    assign unused_bits = csr_funct3[2];

    assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};
    assign mie_val     = {20'd0, mie_meie_reg, 3'd0, mie_mtie_reg, 7'd0};
    assign mip_val     = {20'd0, mip_meip_reg, 3'd0, mip_mtip_reg, 7'd0};
    assign mtvec_val   = {mtvec_reg, 2'b00};
    assign mepc_val    = {mepc_reg, 2'b00};

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = mstatus_val;
            A_MIE:      csr_rdata = mie_val;
            A_MTVEC:    csr_rdata = mtvec_val;
            A_MSCRATCH: csr_rdata = mscratch_reg;
            A_MEPC:     csr_rdata = mepc_val;
            A_MCAUSE:   csr_rdata = mcause_reg;
            A_MIP:      csr_rdata = mip_val;
            12'hB00:    csr_rdata = cnt[0][31:0];
            12'hB80:    csr_rdata = cnt[0][63:32];
            12'hB02:    csr_rdata = cnt[1][31:0];
            12'hB82:    csr_rdata = cnt[1][63:32];
            default:    csr_rdata = 32'd0;
        endcase
    end

    always_comb begin
        write_val = csr_rdata;
        case (csr_funct3[1:0])
            2'b01:   write_val = csr_wdata;
            2'b10:   write_val = csr_rdata | csr_wdata;
            2'b11:   write_val = csr_rdata & ~csr_wdata;
            default: write_val = csr_rdata;
        endcase
    end

    // Set/clear with a zero mask is a pure read and must not disturb the counters
    assign csr_write = rst_n && (state_reg == ST_RUN) && csr_en &&
                       ((csr_funct3[1:0] == 2'b01) ||
                        ((csr_funct3[1:0] != 2'b00) && (csr_wdata != 32'd0)));

    assign pend_ext = mie_meie_reg & mip_meip_reg;
    assign pend_tmr = mie_mtie_reg & mip_mtip_reg;
    assign pending  = pend_ext | pend_tmr;
    assign take     = mstatus_mie_reg & pending;

    assign irq_run   = (state_reg == ST_RUN) && take && !csr_en && !mret;
    assign irq_sleep = (state_reg == ST_SLEEP) && take;

    assign CSR_ret       = rst_n && (state_reg == ST_RUN) && mret;
    assign CSR_interrupt = rst_n && (irq_run || irq_sleep);
    assign wfi_stall     = rst_n && (state_reg == ST_SLEEP);

    always_comb begin
        trap_pc = 32'd0;
        if (CSR_interrupt)
            trap_pc = mtvec_val;
        else if (CSR_ret)
            trap_pc = mepc_val;
    end

    // A branch redirect in flight supersedes whatever sits in ID/IF
    always_comb begin
        mepc_entry = IF_pc;
        if (CSR_type == 2'd0)
            mepc_entry = branch_target;
        else if (ID_valid)
            mepc_entry = ID_pc;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (CSR_ret || CSR_interrupt)
                    state_next = ST_FLUSH;
                else if (wfi && !take)
                    state_next = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (pending)
                    state_next = mstatus_mie_reg ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= ST_RUN;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mip_meip_reg <= 1'b0;
            mip_mtip_reg <= 1'b0;
        end else begin
            mip_meip_reg <= ext_irq;
            mip_mtip_reg <= timer_irq;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_meie_reg     <= 1'b0;
            mie_mtie_reg     <= 1'b0;
            mtvec_reg        <= MTVEC_RST[31:2];
            mscratch_reg     <= 32'd0;
            mepc_reg         <= 30'd0;
            mcause_reg       <= 32'd0;
        end else begin
            if (csr_write) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mstatus_mie_reg  <= write_val[3];
                        mstatus_mpie_reg <= write_val[7];
                    end
                    A_MIE: begin
                        mie_meie_reg <= write_val[11];
                        mie_mtie_reg <= write_val[7];
                    end
                    A_MTVEC:    mtvec_reg    <= write_val[31:2];
                    A_MSCRATCH: mscratch_reg <= write_val;
                    A_MEPC:     mepc_reg     <= write_val[31:2];
                    A_MCAUSE:   mcause_reg   <= write_val;
                    default: ;
                endcase
            end
            if (CSR_ret) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end
            if (CSR_interrupt) begin
                mepc_reg         <= mepc_entry[31:2];
                mcause_reg       <= pend_ext ? CAUSE_MEI : CAUSE_MTI;
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            localparam logic [11:0] LO_ADDR = 12'hB00 | 12'(2 * gi);
            localparam logic [11:0] HI_ADDR = 12'hB80 | 12'(2 * gi);

            logic [63:0] cnt_reg;
            logic        inc;
            logic        wr_lo;
            logic        wr_hi;

            assign inc   = (gi == 0) ? 1'b1 : instret_inc;
            assign wr_lo = csr_write && (csr_addr == LO_ADDR);
            assign wr_hi = csr_write && (csr_addr == HI_ADDR);

            always_ff @(posedge clk) begin
                if (!rst_n)
                    cnt_reg <= 64'd0;
                else if (wr_lo)
                    cnt_reg[31:0] <= write_val;
                else if (wr_hi)
                    cnt_reg[63:32] <= write_val;
                else if (inc)
                    cnt_reg <= cnt_reg + 64'd1;
            end

            assign cnt[gi] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit: CSR ops, interrupt entry,
// mret, wfi sleep, counter carry and reset behaviour.
module tb_csr_trap_unit;

    logic        clk;
    logic        rst_n;
    logic        csr_en;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        mret;
    logic        wfi;
    logic        instret_inc;
    logic        ext_irq;
    logic        timer_irq;
    logic [1:0]  CSR_type;
    logic [31:0] branch_target;
    logic [31:0] ID_pc;
    logic        ID_valid;
    logic [31:0] IF_pc;
    logic        CSR_interrupt;
    logic        CSR_ret;
    logic [31:0] trap_pc;
    logic        wfi_stall;

    int checks   = 0;
    int failures = 0;

    csr_trap_unit #(
        .XLEN      (32),
        .MTVEC_RST (32'h0000_0400)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_en        (csr_en),
        .csr_funct3    (csr_funct3),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_rdata     (csr_rdata),
        .mret          (mret),
        .wfi           (wfi),
        .instret_inc   (instret_inc),
        .ext_irq       (ext_irq),
        .timer_irq     (timer_irq),
        .CSR_type      (CSR_type),
        .branch_target (branch_target),
        .ID_pc         (ID_pc),
        .ID_valid      (ID_valid),
        .IF_pc         (IF_pc),
        .CSR_interrupt (CSR_interrupt),
        .CSR_ret       (CSR_ret),
        .trap_pc       (trap_pc),
        .wfi_stall     (wfi_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic csr_op(input string tag, input logic [2:0] f, input logic [11:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_old, input bit do_chk);
        csr_en     = 1'b1;
        csr_funct3 = f;
        csr_addr   = a;
        csr_wdata  = wd;
        #1;
        if (do_chk)
            chk(tag, csr_rdata, exp_old);
        tick();
        csr_en    = 1'b0;
        csr_wdata = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; csr_en = 1'b0; csr_funct3 = 3'd0; csr_addr = 12'd0; csr_wdata = 32'd0;
        mret = 1'b1; wfi = 1'b0; instret_inc = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
        CSR_type = 2'd2; branch_target = 32'd0; ID_pc = 32'd0; ID_valid = 1'b1; IF_pc = 32'd0;

        // Reset: outputs quiet even with mret asserted, CSRs at reset values
        tick(); tick();
        chk("rst_ret", {31'd0, CSR_ret}, 32'd0);
        chk("rst_trap_pc", trap_pc, 32'd0);
        chk("rst_stall", {31'd0, wfi_stall}, 32'd0);
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rst_mtvec", 12'h305, 32'h0000_0400);
        rd_chk("rst_mcycle", 12'hB00, 32'd0);
        mret  = 1'b0;
        rst_n = 1'b1;
        tick();

        // CSR op sequence on mscratch
        csr_op("rw_mscratch", 3'b001, 12'h340, 32'hDEAD_BEEF, 32'd0, 1'b1);
        csr_op("rs_mscratch", 3'b010, 12'h340, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1);
        csr_op("rc_mscratch", 3'b111, 12'h340, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b1);
        rd_chk("mscratch_fin", 12'h340, 32'hDEAD_BE0F);
        csr_op("rw_mepc", 3'b001, 12'h341, 32'h0000_0123, 32'd0, 1'b1);
        rd_chk("mepc_align", 12'h341, 32'h0000_0120);
        csr_op("rw_mip", 3'b001, 12'h344, 32'hFFFF_FFFF, 32'd0, 1'b1);
        rd_chk("mip_ro", 12'h344, 32'd0);
        rd_chk("unmapped", 12'h7C0, 32'd0);

        // Timer interrupt during a load-use stall
        csr_op("rw_mie", 3'b001, 12'h304, 32'h0000_0080, 32'd0, 1'b1);
        csr_op("rw_mtvec", 3'b001, 12'h305, 32'h0000_0100, 32'h0000_0400, 1'b1);
        csr_op("rs_mstatus", 3'b010, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b1);
        CSR_type = 2'd1; ID_pc = 32'h48; ID_valid = 1'b1; IF_pc = 32'h4C;
        timer_irq = 1'b1;
        #1; chk("tmr_c0_int", {31'd0, CSR_interrupt}, 32'd0);
        tick();
        chk("tmr_c1_int", {31'd0, CSR_interrupt}, 32'd1);
        chk("tmr_c1_pc", trap_pc, 32'h0000_0100);
        tick();
        chk("tmr_flush_int", {31'd0, CSR_interrupt}, 32'd0);
        rd_chk("tmr_mepc", 12'h341, 32'h0000_0048);
        rd_chk("tmr_mcause", 12'h342, 32'h8000_0007);
        rd_chk("tmr_mstatus", 12'h300, 32'h0000_1880);
        tick();

        // mret, with the timer still pending when MIE comes back
        mret = 1'b1;
        #1;
        chk("mret_ret", {31'd0, CSR_ret}, 32'd1);
        chk("mret_pc", trap_pc, 32'h0000_0048);
        chk("mret_int", {31'd0, CSR_interrupt}, 32'd0);
        tick();
        mret = 1'b0;
        chk("mret_flush_int", {31'd0, CSR_interrupt}, 32'd0);
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        timer_irq = 1'b0;
        tick();
        chk("post_mret_int", {31'd0, CSR_interrupt}, 32'd0);

        // Both sources together on a branch redirect
        csr_op("rs_mie", 3'b010, 12'h304, 32'h0000_0800, 32'h0000_0080, 1'b1);
        CSR_type = 2'd0; branch_target = 32'h200;
        ext_irq = 1'b1; timer_irq = 1'b1;
        #1; chk("both_c0_int", {31'd0, CSR_interrupt}, 32'd0);
        tick();
        chk("both_c1_int", {31'd0, CSR_interrupt}, 32'd1);
        tick();
        ext_irq = 1'b0; timer_irq = 1'b0;
        rd_chk("both_mcause", 12'h342, 32'h8000_000B);
        rd_chk("both_mepc", 12'h341, 32'h0000_0200);
        tick();
        mret = 1'b1;
        #1; chk("both_ret_pc", trap_pc, 32'h0000_0200);
        tick();
        mret = 1'b0;
        tick();

        // WFI with MIE clear: wake without trapping
        csr_op("rc_mstatus", 3'b011, 12'h300, 32'h0000_0008, 32'h0000_1888, 1'b1);
        wfi = 1'b1;
        #1; chk("wfi0_stall", {31'd0, wfi_stall}, 32'd0);
        tick();
        wfi = 1'b0; ext_irq = 1'b1;
        chk("wfi1_stall", {31'd0, wfi_stall}, 32'd1);
        tick();
        chk("wfi2_stall", {31'd0, wfi_stall}, 32'd1);
        chk("wfi2_int", {31'd0, CSR_interrupt}, 32'd0);
        tick();
        chk("wfi3_stall", {31'd0, wfi_stall}, 32'd0);
        chk("wfi3_int", {31'd0, CSR_interrupt}, 32'd0);
        ext_irq = 1'b0;
        tick();

        // WFI with MIE set and a bubble in ID: trap saves IF_pc
        csr_op("rs_mstatus2", 3'b010, 12'h300, 32'h0000_0008, 32'h0000_1880, 1'b1);
        CSR_type = 2'd1; ID_valid = 1'b0; IF_pc = 32'h64;
        wfi = 1'b1;
        tick();
        wfi = 1'b0; ext_irq = 1'b1;
        chk("wfiv1_stall", {31'd0, wfi_stall}, 32'd1);
        chk("wfiv1_int", {31'd0, CSR_interrupt}, 32'd0);
        tick();
        chk("wfiv2_stall", {31'd0, wfi_stall}, 32'd1);
        chk("wfiv2_int", {31'd0, CSR_interrupt}, 32'd1);
        chk("wfiv2_pc", trap_pc, 32'h0000_0100);
        tick();
        ext_irq = 1'b0;
        chk("wfiv3_stall", {31'd0, wfi_stall}, 32'd0);
        rd_chk("wfiv_mepc", 12'h341, 32'h0000_0064);
        rd_chk("wfiv_mcause", 12'h342, 32'h8000_000B);
        tick();

        // Counter carry across halves and write-suppressed increment
        csr_op("rw_mcycle", 3'b001, 12'hB00, 32'hFFFF_FFFF, 32'd0, 1'b0);
        csr_op("rw_mcycleh", 3'b001, 12'hB80, 32'd0, 32'd0, 1'b0);
        rd_chk("mcycleh_a", 12'hB80, 32'd0);
        rd_chk("mcycle_a", 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd_chk("mcycleh_b", 12'hB80, 32'd1);
        rd_chk("mcycle_b", 12'hB00, 32'd0);
        instret_inc = 1'b1;
        csr_op("rw_minstret", 3'b001, 12'hB02, 32'h0000_0010, 32'd0, 1'b0);
        rd_chk("minstret_a", 12'hB02, 32'h0000_0010);
        tick();
        instret_inc = 1'b0;
        rd_chk("minstret_b", 12'hB02, 32'h0000_0011);
        tick();
        rd_chk("minstret_c", 12'hB02, 32'h0000_0011);

        // Reset while sleeping
        wfi = 1'b1;
        tick();
        wfi = 1'b0;
        chk("rs_sleep_stall", {31'd0, wfi_stall}, 32'd1);
        rst_n = 1'b0;
        #1; chk("rs_low_stall", {31'd0, wfi_stall}, 32'd0);
        tick(); tick();
        rd_chk("rs_mcycle", 12'hB00, 32'd0);
        rd_chk("rs_minstret", 12'hB02, 32'd0);
        rd_chk("rs_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rs_mscratch", 12'h340, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rs_run_stall", {31'd0, wfi_stall}, 32'd0);
        chk("rs_run_int", {31'd0, CSR_interrupt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
